// File: rtl/lockin_pkg.sv
// lockin_pkg: shared state type and arithmetic helpers for multichannel_lockin
package lockin_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DUMP} state_e;
  function automatic int acc_width(input int w_in, input int decim_log2);
    return w_in + 1 + decim_log2;
  endfunction
  function automatic logic signed [63:0] scale_product(input logic signed [31:0] a,
                                                      input logic signed [31:0] b,
                                                      input int w);
    return (64'(a) * 64'(b)) >>> (w - 1);
  endfunction
endpackage

// File: rtl/lockin_mac_unit.sv
// lockin_mac_unit: reference latch plus the shared I/Q multiplier pair with floor shift
module lockin_mac_unit #(
  parameter int W_IN = 24
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   load_i,
  input  logic [W_IN-1:0]        sin_i,
  input  logic [W_IN-1:0]        cos_i,
  input  logic [W_IN-1:0]        sig_i,
  output logic signed [W_IN:0]   p_i_o,
  output logic signed [W_IN:0]   p_q_o
);
  import lockin_pkg::*;
  logic [W_IN-1:0] sin_q, sin_d, cos_q, cos_d;
  always_comb begin
    sin_d = load_i ? sin_i : sin_q;
    cos_d = load_i ? cos_i : cos_q;
    p_i_o = (W_IN+1)'(scale_product(32'(signed'(sig_i)), 32'(signed'(cos_q)), W_IN));
    p_q_o = (W_IN+1)'(scale_product(32'(signed'(sig_i)), 32'(signed'(sin_q)), W_IN));
  end
  always_ff @(posedge clk_i) begin
    sin_q <= reset_ni ? sin_d : '0;
    cos_q <= reset_ni ? cos_d : '0;
  end
endmodule

// File: rtl/multichannel_lockin.sv
// multichannel_lockin: time-multiplexed I/Q lock-in demodulator with boxcar decimation
module multichannel_lockin #(
  parameter int NUM_CH     = 4,
  parameter int W_IN       = 24,
  parameter int W_OUT      = 32,
  parameter int DECIM_LOG2 = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    tick_i,
  input  logic                    clear_i,
  input  logic [NUM_CH*W_IN-1:0]  sig_i,
  input  logic [W_IN-1:0]         sin_i,
  input  logic [W_IN-1:0]         cos_i,
  output logic [NUM_CH*W_OUT-1:0] i_o,
  output logic [NUM_CH*W_OUT-1:0] q_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic [31:0]             frame_count_o
);
  import lockin_pkg::*;
  localparam int AW = acc_width(W_IN, DECIM_LOG2);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = DECIM_LOG2 > 0 ? DECIM_LOG2 : 1;
  localparam logic [IW-1:0] LAST_CH  = IW'(NUM_CH - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << DECIM_LOG2) - 1);
  if (W_OUT < W_IN + 1) begin : g_bad_w_out
    $error("W_OUT must be at least W_IN+1");
  end
  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_CH*W_IN-1:0]   sig_q, sig_d;
  logic signed [AW-1:0]     acc_i_q [NUM_CH];
  logic signed [AW-1:0]     acc_i_d [NUM_CH];
  logic signed [AW-1:0]     acc_q_q [NUM_CH];
  logic signed [AW-1:0]     acc_q_d [NUM_CH];
  logic [NUM_CH*W_OUT-1:0]  i_q, i_d, q_q, q_d;
  logic                     done_q, done_d, ovr_q, ovr_d;
  logic [31:0]              frame_q, frame_d;
  logic signed [W_IN:0]     p_i, p_q;
  logic                     load;
  // Mean keeps only the W_IN+1 meaningful bits, then sign-extends to the output width.
  function automatic logic [W_OUT-1:0] mean(input logic signed [AW-1:0] a);
    return W_OUT'(signed'((W_IN+1)'(a >>> DECIM_LOG2)));
  endfunction
  assign load = (state_q == IDLE) && tick_i && !clear_i;
  lockin_mac_unit #(.W_IN(W_IN)) u_mac (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .load_i  (load),
    .sin_i   (sin_i),
    .cos_i   (cos_i),
    .sig_i   (sig_q[idx_q*W_IN +: W_IN]),
    .p_i_o   (p_i),
    .p_q_o   (p_q)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    i_d     = i_q;
    q_d     = q_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (tick_i & ~clear_i & (state_q != IDLE));
    if (clear_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc_i_d[k] = '0;
        acc_q_d[k] = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = tick_i ? MAC : IDLE;
          idx_d   = tick_i ? '0 : idx_q;
          sig_d   = tick_i ? sig_i : sig_q;
        end
        MAC: begin
          acc_i_d[idx_q] = acc_i_q[idx_q] + AW'(p_i);
          acc_q_d[idx_q] = acc_q_q[idx_q] + AW'(p_q);
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_CH) begin
            idx_d   = '0;
            state_d = cnt_q == LAST_CNT ? DUMP : IDLE;
            cnt_d   = cnt_q == LAST_CNT ? cnt_q : cnt_q + 1'b1;
          end
        end
        default: begin
          for (int k = 0; k < NUM_CH; k++) begin
            i_d[k*W_OUT +: W_OUT] = mean(acc_i_q[k]);
            q_d[k*W_OUT +: W_OUT] = mean(acc_q_q[k]);
            acc_i_d[k] = '0;
            acc_q_d[k] = '0;
          end
          cnt_d   = '0;
          frame_d = frame_q + 32'd1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc_i_q[k] <= '0;
        acc_q_q[k] <= '0;
      end
      i_q     <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      i_q     <= i_d;
      q_q     <= q_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      frame_q <= frame_d;
    end
  end
  assign i_o           = i_q;
  assign q_o           = q_q;
  assign done_o        = done_q;
  assign busy_o        = state_q != IDLE;
  assign overrun_o     = ovr_q;
  assign frame_count_o = frame_q;
endmodule
